// File: rtl/inst_mem_axi_slave_pkg.sv
// inst_mem_axi_slave_pkg: FSM state encoding and AXI response codes shared by the
// instruction-memory AXI responder.
package inst_mem_axi_slave_pkg;
   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_DATA, WR_RESP} state_t;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/inst_mem_bram.sv
// inst_mem_bram: single-port word RAM with byte enables and a registered read port;
// the read register holds its value until the next read enable.
module inst_mem_bram #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                en_i,
   input  logic [DATA_W/8-1:0] we_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   output logic [DATA_W-1:0]   rdata_o
);
   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;
   always_ff @(posedge clk_i)
      for (int i = 0; i < DATA_W/8; i++)
         if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) rdata_q <= '0;
      else if (en_i) rdata_q <= mem_q[addr_i];
   assign rdata_o = rdata_q;
endmodule

// File: rtl/inst_mem_axi_slave.sv
// inst_mem_axi_slave: AXI4 INCR-burst responder serving instruction memory from a
// block RAM, one transaction at a time, reads taking priority over writes.
module inst_mem_axi_slave
   import inst_mem_axi_slave_pkg::*;
#(
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int MEM_WORDS_LOG2     = 12
) (
   input  logic                            CCLK,
   input  logic                            CRST,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [7:0]                      S_AXI_AWLEN,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WLAST,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [7:0]                      S_AXI_ARLEN,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RLAST,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY
);
   state_t                    state_q, state_d;
   logic [MEM_WORDS_LOG2-1:0] addr_q, addr_d;
   logic [7:0]                len_q, len_d, beat_q, beat_d;
   logic                      err_q, err_d, rdy_q, last;
   logic                      unused_addr;
   assign unused_addr = ^{S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:MEM_WORDS_LOG2+2], S_AXI_ARADDR[1:0],
                          S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:MEM_WORDS_LOG2+2], S_AXI_AWADDR[1:0]};
   assign last = beat_q == len_q;
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      beat_d  = beat_q;
      err_d   = err_q;
      case (state_q)
         IDLE:
            if (rdy_q && S_AXI_ARVALID) begin
               addr_d  = S_AXI_ARADDR[MEM_WORDS_LOG2+1:2];
               len_d   = S_AXI_ARLEN;
               beat_d  = '0;
               state_d = RD_ADDR;
            end else if (rdy_q && S_AXI_AWVALID) begin
               addr_d  = S_AXI_AWADDR[MEM_WORDS_LOG2+1:2];
               len_d   = S_AXI_AWLEN;
               beat_d  = '0;
               err_d   = 1'b0;
               state_d = WR_DATA;
            end
         RD_ADDR: state_d = RD_DATA;
         RD_DATA:
            if (S_AXI_RREADY) begin
               addr_d  = addr_q + (MEM_WORDS_LOG2)'(1);
               beat_d  = beat_q + 8'd1;
               state_d = last ? IDLE : RD_ADDR;
            end
         WR_DATA:
            if (S_AXI_WVALID) begin
               addr_d  = addr_q + (MEM_WORDS_LOG2)'(1);
               beat_d  = beat_q + 8'd1;
               err_d   = err_q | (S_AXI_WLAST != last);
               state_d = last ? WR_RESP : WR_DATA;
            end
         WR_RESP: state_d = S_AXI_BREADY ? IDLE : WR_RESP;
         default: state_d = IDLE;
      endcase
   end
   // Ready is registered from the next state so it is low during and one cycle after reset.
   always_ff @(posedge CCLK or posedge CRST)
      if (CRST) begin
         state_q <= IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         beat_q  <= '0;
         err_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
         rdy_q   <= state_d == IDLE;
      end
   inst_mem_bram #(.ADDR_W(MEM_WORDS_LOG2), .DATA_W(C_S_AXI_DATA_WIDTH)) u_bram (
      .clk_i   (CCLK),
      .rst_i   (CRST),
      .en_i    (state_q == RD_ADDR),
      .we_i    ((state_q == WR_DATA && S_AXI_WVALID) ? S_AXI_WSTRB : '0),
      .addr_i  (addr_q),
      .wdata_i (S_AXI_WDATA),
      .rdata_o (S_AXI_RDATA)
   );
   assign S_AXI_ARREADY = rdy_q;
   assign S_AXI_AWREADY = rdy_q;
   assign S_AXI_WREADY  = state_q == WR_DATA;
   assign S_AXI_BVALID  = state_q == WR_RESP;
   assign S_AXI_BRESP   = (S_AXI_BVALID && err_q) ? RESP_SLVERR : RESP_OKAY;
   assign S_AXI_RVALID  = state_q == RD_DATA;
   assign S_AXI_RLAST   = S_AXI_RVALID && last;
   assign S_AXI_RRESP   = RESP_OKAY;
endmodule

// File: tb/tb_inst_mem_axi_slave.sv
// tb_inst_mem_axi_slave: table-driven write/read vectors plus burst, priority, error,
// wrap and async-reset sequences, with a read-data scoreboard fed from a memory model.
module tb_inst_mem_axi_slave;
   logic        clk = 1'b0, rst = 1'b1;
   logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
   logic [7:0]  awlen = '0, arlen = '0;
   logic [3:0]  wstrb = '0;
   logic [1:0]  bresp, rresp;
   logic        awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;
   logic        arvalid = 0, arready, rlast, rvalid, rready = 0;
   typedef struct { logic [31:0] data; logic last; } rexp_t;
   typedef struct { logic [31:0] waddr, raddr, pre, wd; logic [3:0] strb; logic [31:0] exp; } vec_t;
   rexp_t       sb[$];
   logic [31:0] model [4096];
   vec_t        vecs [7];
   int          passed = 0, total = 0;

   always #5 clk = ~clk;

   inst_mem_axi_slave dut (
      .CCLK(clk), .CRST(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
      .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid),
      .S_AXI_RREADY(rready)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push_model(input logic [31:0] a, input logic [7:0] len);
      for (int b = 0; b <= int'(len); b++) begin
         logic [11:0] i = a[13:2] + 12'(b);
         sb.push_back('{model[i], b == int'(len)});
      end
   endtask

   task automatic aw_phase(input logic [31:0] a, input logic [7:0] len);
      int n = 0;
      @(posedge clk); #1;
      awaddr = a; awlen = len; awvalid = 1;
      do begin @(negedge clk); n++; end while (!awready && n < 200);
      if (!awready) chk("aw_timeout", awready, 1);
      @(posedge clk); #1;
      awvalid = 0;
   endtask

   task automatic w_phase(input logic [31:0] a, input logic [7:0] len, input logic [31:0] base,
                          input logic [3:0] strb, input bit wlast_all, input logic [1:0] exp_resp);
      for (int b = 0; b <= int'(len); b++) begin
         logic [11:0] i = a[13:2] + 12'(b);
         int n = 0;
         wdata = base + b; wstrb = strb; wlast = wlast_all || b == int'(len); wvalid = 1;
         do begin @(negedge clk); n++; end while (!wready && n < 200);
         if (!wready) chk("w_timeout", wready, 1);
         @(posedge clk);
         for (int k = 0; k < 4; k++) if (strb[k]) model[i][8*k +: 8] = wdata[8*k +: 8];
         #1;
      end
      wvalid = 0; wlast = 0; bready = 1;
      @(negedge clk);
      chk("b_valid_latency", bvalid, 1);
      chk("b_resp", bresp, exp_resp);
      @(posedge clk); #1;
      bready = 0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [31:0] base,
                           input logic [3:0] strb, input bit wlast_all, input logic [1:0] exp_resp);
      aw_phase(a, len);
      w_phase(a, len, base, strb, wlast_all, exp_resp);
   endtask

   task automatic do_read(input logic [31:0] a, input logic [7:0] len, input bit toggle, input bit lat);
      int    n = 0, cyc = 0, first = -1;
      bit    stalled = 0;
      logic [32:0] held = '0;
      rexp_t e;
      @(posedge clk); #1;
      araddr = a; arlen = len; arvalid = 1; rready = 1;
      do begin @(negedge clk); n++; end while (!arready && n < 200);
      if (!arready) chk("ar_timeout", arready, 1);
      @(posedge clk); #1;
      arvalid = 0;
      while (sb.size() > 0 && cyc < 2000) begin
         @(negedge clk); cyc++;
         if (rvalid) begin
            if (first < 0) first = cyc;
            if (stalled) chk("r_stable", {rlast, rdata}, held);
            if (rready) begin
               e = sb.pop_front();
               chk("r_data", rdata, e.data);
               chk("r_last", rlast, e.last);
               chk("r_resp", rresp, 2'b00);
               stalled = 0;
            end else begin
               stalled = 1; held = {rlast, rdata};
            end
         end
         if (sb.size() > 0) begin @(posedge clk); #1; rready = toggle ? !rready : 1'b1; end
      end
      if (sb.size() > 0) begin chk("r_timeout", rvalid, 1); sb.delete(); end
      if (lat) chk("r_latency", 64'(first), 64'd2);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rexp_t e;
      vecs = '{
         '{32'h10,       32'h10, 32'h0,        32'hDEADBEEF, 4'hF, 32'hDEADBEEF},
         '{32'h14,       32'h14, 32'hFFFFFFFF, 32'h11223344, 4'h5, 32'hFF22FF44},
         '{32'h20,       32'h20, 32'hAAAAAAAA, 32'h12345678, 4'h8, 32'h12AAAAAA},
         '{32'h24,       32'h24, 32'h0BADF00D, 32'hCAFEF00D, 4'h0, 32'h0BADF00D},
         '{32'h28,       32'h28, 32'h55555555, 32'h0000FFFF, 4'h3, 32'h5555FFFF},
         '{32'h80000030, 32'h31, 32'h13579BDF, 32'h2468ACE0, 4'hF, 32'h2468ACE0},
         '{32'h00004034, 32'h36, 32'h0,        32'h0F0F0F0F, 4'h6, 32'h000F0F00}
      };
      repeat (2) @(negedge clk);
      chk("rst_ready", {arready, awready, wready}, 0);
      chk("rst_valid", {bvalid, rvalid, rlast}, 0);
      chk("rst_data", {bresp, rdata}, 0);
      #1 rst = 0;
      @(negedge clk);
      chk("ready_after_rst", {arready, awready}, 2'b11);

      foreach (vecs[v]) begin
         do_write(vecs[v].waddr, 0, vecs[v].pre, 4'hF, 0, 2'b00);
         do_write(vecs[v].waddr, 0, vecs[v].wd, vecs[v].strb, 0, 2'b00);
         sb.push_back('{vecs[v].exp, 1'b1});
         do_read(vecs[v].raddr, 0, 0, 1);
      end

      do_write(32'h0, 3, 32'd1, 4'hF, 0, 2'b00);
      sb.push_back('{32'd1, 1'b0}); sb.push_back('{32'd2, 1'b0});
      sb.push_back('{32'd3, 1'b0}); sb.push_back('{32'd4, 1'b1});
      do_read(32'h0, 3, 1, 1);

      do_write(32'h60, 1, 32'h77, 4'hF, 1, 2'b10);
      push_model(32'h60, 1);
      do_read(32'h60, 1, 0, 0);
      do_write(32'h3FFC, 1, 32'hA000, 4'hF, 0, 2'b00);
      sb.push_back('{32'hA000, 1'b0}); sb.push_back('{32'hA001, 1'b1});
      do_read(32'h3FFC, 1, 0, 0);

      push_model(32'h0, 0);
      @(posedge clk); #1;
      araddr = 0; arlen = 0; arvalid = 1; awaddr = 32'h40; awlen = 0; awvalid = 1; rready = 1;
      n = 0;
      do begin @(negedge clk); n++; end while (!arready && n < 200);
      if (!arready) chk("ar4_timeout", arready, 1);
      @(posedge clk); #1;
      arvalid = 0;
      n = 0;
      while (sb.size() > 0 && n < 100) begin
         @(negedge clk); n++;
         chk("aw_blocked", awready, 0);
         if (rvalid && rready) begin
            e = sb.pop_front();
            chk("prio_rdata", rdata, e.data);
            chk("prio_rlast", rlast, e.last);
         end
      end
      if (sb.size() > 0) begin chk("prio_timeout", rvalid, 1); sb.delete(); end
      @(posedge clk); #1;
      @(negedge clk);
      chk("aw_after_read", awready, 1);
      @(posedge clk); #1;
      awvalid = 0;
      w_phase(32'h40, 0, 32'h5A5A0000, 4'hF, 0, 2'b00);
      push_model(32'h40, 0);
      do_read(32'h40, 0, 0, 0);

      do_write(32'h50, 3, 32'h600, 4'hF, 0, 2'b00);
      @(posedge clk); #1;
      araddr = 32'h50; arlen = 3; arvalid = 1; rready = 1;
      n = 0;
      do begin @(negedge clk); n++; end while (!arready && n < 200);
      @(posedge clk); #1;
      arvalid = 0;
      for (int b = 0; b < 2; b++) begin
         n = 0;
         do begin @(negedge clk); n++; end while (!rvalid && n < 20);
         chk("rst_pre_beat", rdata, model[20 + b]);
         if (b == 0) begin @(posedge clk); #1; end
      end
      #1 rst = 1;
      #1;
      chk("rst_async_rvalid", rvalid, 0);
      chk("rst_async_rdata", rdata, 0);
      chk("rst_async_arready", arready, 0);
      @(negedge clk); #1 rst = 0;
      #1 chk("arready_low_at_release", arready, 0);
      @(negedge clk);
      chk("arready_after_release", arready, 1);
      chk("idle_after_release", {rvalid, bvalid, wready}, 0);
      push_model(32'h50, 3);
      do_read(32'h50, 3, 0, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/inst_mem_axi_slave.md
Name: inst_mem_axi_slave

Overview:
AXI4 responder (slave) that answers the CPU core's M_INST_AXI_* master port from an internal word-addressed block RAM holding program/instruction memory.
Sits between core and the top-level wrapper: core fetches and stores through AW/W/B/AR/R, this block serves them.
Supports INCR bursts with fixed 4-byte beats (SIZE=3'b010, BURST=2'b01), so the SIZE/BURST/LOCK/CACHE/PROT/QOS/USER/ID signals have no ports here.
One transaction is outstanding at a time, so master BID/RID are tied to 0 at the top level.

Parameters:
C_S_AXI_ADDR_WIDTH, 32, byte address width.
C_S_AXI_DATA_WIDTH, 32, data width; only 32 supported.
MEM_WORDS_LOG2, 12, memory depth = 2^MEM_WORDS_LOG2 32-bit words.

Ports:
CCLK  in  1  clock for all logic and memory
CRST  in  1  reset, asynchronous, active-high
S_AXI_AWADDR  in  32  write burst start byte address
S_AXI_AWLEN  in  8  write beats minus 1
S_AXI_AWVALID  in  1  AW valid
S_AXI_AWREADY  out  1  AW ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WLAST  in  1  final write beat marker
S_AXI_WVALID  in  1  W valid
S_AXI_WREADY  out  1  W ready
S_AXI_BRESP  out  2  write response, 2'b00 OKAY or 2'b10 SLVERR
S_AXI_BVALID  out  1  B valid
S_AXI_BREADY  in  1  B ready
S_AXI_ARADDR  in  32  read burst start byte address
S_AXI_ARLEN  in  8  read beats minus 1
S_AXI_ARVALID  in  1  AR valid
S_AXI_ARREADY  out  1  AR ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always 2'b00
S_AXI_RLAST  out  1  final read beat
S_AXI_RVALID  out  1  R valid
S_AXI_RREADY  in  1  R ready

Behaviour:
- Clock and reset: one clock, CCLK. Reset CRST is asynchronous and active-high.
- Reset values: state IDLE; AWREADY/ARREADY/WREADY/BVALID/RVALID/RLAST=0; RDATA=0; BRESP=0. Memory is not cleared.
- Reset mid-operation: CRST mid-burst aborts the transaction immediately. Words already written are kept.
- Addressing: word index = addr[MEM_WORDS_LOG2+1:2]. Upper and lower bits are ignored. Beat address increments by 4 and wraps modulo memory size.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_DATA, WR_RESP.
- IDLE: ARREADY = AWREADY = (state==IDLE), registered and deasserted during CRST.
  - ARVALID: latch ARADDR/ARLEN, go to RD_ADDR.
  - Else AWVALID: latch AWADDR/AWLEN, clear error flag, go to WR_DATA.
  - ARVALID and AWVALID together: read wins; AW stays pending.
- RD_ADDR: issue the synchronous memory read, go to RD_DATA.
- RD_DATA: RVALID=1; RLAST=(beat==len).
  - RDATA, RLAST and RVALID stay stable until RREADY.
  - On handshake: last beat goes to IDLE; otherwise addr+=4, beat+=1, go to RD_ADDR.
  - Latency: AR handshake at cycle t gives first RVALID at t+2. Sustained rate is 1 beat per 2 cycles.
- WR_DATA: WREADY=1.
  - On handshake: write bytes enabled by WSTRB, addr+=4, beat+=1.
  - Set the error flag if WLAST != (beat==len).
  - Burst length is set by AWLEN, not WLAST. After beat len, go to WR_RESP.
- WR_RESP: BVALID=1 with BRESP = error ? 2'b10 : 2'b00, held until BREADY; then go to IDLE.
  - Latency: BVALID is asserted the cycle after the last W handshake.
- Read-after-write: a read accepted after BVALID/BREADY returns the new data.
- Counters: beat counter is 8 bits; len=255 gives 256 beats.

Decomposition:
- Shared package: the FSM state encoding and the AXI response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
- One sub-module, inst_mem_bram: single-port RAM, byte-write, 1-cycle read latency.

Test Plan:
1. AW 0x10 len0, W 0xDEADBEEF strb 4'hF WLAST=1, then AR 0x10 len0 -> BRESP 00 one cycle after W; RDATA 0xDEADBEEF with RLAST=1, RVALID at AR+2.
2. Preload words 0..3 = 1,2,3,4; AR 0x0 len3 with RREADY toggling 1/0 -> beats 1,2,3,4 in order, data stable during stalls, RLAST only on beat 4.
3. Word 5 = 0xFFFFFFFF; write 0x11223344 strb 4'b0101 to 0x14 -> read back 0xFF22FF44.
4. ARVALID and AWVALID asserted together in IDLE -> AR accepted first, AWREADY=0 until RLAST handshake; write then completes with OKAY.
5. AW len1 with WLAST=1 on both beats -> two beats written, BRESP=2'b10. Separately, AR at byte 4*(2^MEM_WORDS_LOG2-1) len1 -> second beat returns word 0.
6. CRST pulsed during beat 2 of a len3 read -> RVALID drops at once (async); ARREADY=1 the cycle after release; memory contents intact.
